fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 57 +++++
 tb/tb_fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, synchronous instruction fetch and the fetch/decode pipeline register
module fetch_unit #(
   parameter int                   PC_W      = 9,
   parameter int                   INSTR_W   = 34,
   parameter int                   PC_STEP   = 4,
   parameter logic [PC_W-1:0]      RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               StallF,
   input  logic               StallD,
   input  logic               PCSrcE,
   input  logic [PC_W-1:0]    PCTargetE,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] InstrD,
   output logic [PC_W-1:0]    PCD,
   output logic [PC_W-1:0]    PCPlus4D,
   output logic               ValidD,
   output logic               MisalignE,
   output logic [15:0]        redirect_cnt
);
   localparam logic [PC_W-1:0] LOW = PC_W'(PC_STEP - 1);
   logic [PC_W-1:0] pc_f, pc_next, pc_plus, target;
   assign pc_plus   = pc_f + PC_W'(PC_STEP);
   assign target    = PCTargetE & ~LOW;
   assign imem_addr = pc_next;
   // next-PC priority: reset, redirect, fetch stall, sequential
   always_comb pc_next = rst ? RESET_PC : PCSrcE ? target : StallF ? pc_f : pc_plus;
   // fetch PC follows pc_next every cycle, so imem_rdata always matches pc_f
   always_ff @(posedge clk) pc_f <= pc_next;
   // decode register: bubble on reset/redirect, hold on StallD, else capture the fetch
   always_ff @(posedge clk) begin
      if (rst || PCSrcE) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (!StallD) begin
         InstrD   <= imem_rdata;
         PCD      <= pc_f;
         PCPlus4D <= pc_plus;
         ValidD   <= 1'b1;
      end
   end
   // misalignment pulse and saturating redirect counter
   always_ff @(posedge clk) begin
      if (rst) begin
         MisalignE    <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         MisalignE <= PCSrcE && |(PCTargetE & LOW);
         if (PCSrcE && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard for fetch_unit
module tb_fetch_unit;
   logic        clk = 0, rst = 1, StallF = 0, StallD = 0, PCSrcE = 0;
   logic [8:0]  PCTargetE = '0, imem_addr, PCD, PCPlus4D;
   logic [33:0] imem_rdata = '0, InstrD;
   logic        ValidD, MisalignE;
   logic [15:0] redirect_cnt;
   logic [33:0] mem [512];
   int compared = 0, mismatched = 0;

   typedef struct {
      logic [33:0] instr;
      logic [8:0]  pcd, pcp4, addr;
      logic        valid, mis;
      logic [15:0] cnt;
      int          id;
   } exp_t;
   exp_t q[$];

   fetch_unit dut (
      .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .PCSrcE(PCSrcE),
      .PCTargetE(PCTargetE), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .MisalignE(MisalignE), .redirect_cnt(redirect_cnt)
   );

   always #5 clk = ~clk;

   // synchronous 1-cycle read memory
   always @(posedge clk) imem_rdata <= mem[imem_addr];

   function automatic logic [33:0] w(int i);
      return 34'h2_0000_0000 + 34'(i);
   endfunction

   task automatic chk(string n, int id, logic [63:0] a, logic [63:0] e);
      compared++;
      if (a !== e) begin
         mismatched++;
         $display("FAIL cyc%0d %s: got %h expected %h", id, n, a, e);
      end
   endtask

   // monitor: compare the state after each edge against the queued expectation
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("InstrD", e.id, 64'(InstrD), 64'(e.instr));
         chk("PCD", e.id, 64'(PCD), 64'(e.pcd));
         chk("PCPlus4D", e.id, 64'(PCPlus4D), 64'(e.pcp4));
         chk("ValidD", e.id, 64'(ValidD), 64'(e.valid));
         chk("MisalignE", e.id, 64'(MisalignE), 64'(e.mis));
         chk("redirect_cnt", e.id, 64'(redirect_cnt), 64'(e.cnt));
         chk("imem_addr", e.id, 64'(imem_addr), 64'(e.addr));
      end
   end

   int n = 0;
   // drive one cycle of inputs and queue the state expected after the next edge
   task automatic cyc(logic r, logic sf, logic sd, logic src, logic [8:0] tgt,
                      logic [33:0] ei, logic [8:0] epc, logic [8:0] ep4, logic ev,
                      logic em, logic [15:0] ec, logic [8:0] ea);
      exp_t e;
      @(negedge clk);
      #1;
      rst = r; StallF = sf; StallD = sd; PCSrcE = src; PCTargetE = tgt;
      n++;
      e.instr = ei; e.pcd = epc; e.pcp4 = ep4; e.valid = ev;
      e.mis = em; e.cnt = ec; e.addr = ea; e.id = n;
      q.push_back(e);
   endtask

   initial begin
      for (int a = 0; a < 512; a++) mem[a] = w(a / 4);
      //  r  sF sD src tgt     instr  PCD     PCP4    V  M  cnt addr
      cyc(1, 0, 0, 0, 9'h000, 34'h0, 9'h000, 9'h000, 0, 0, 0, 9'h000);
      // sequential stream
      cyc(0, 0, 0, 0, 9'h000, w(0),  9'h000, 9'h004, 1, 0, 0, 9'h008);
      cyc(0, 0, 0, 0, 9'h000, w(1),  9'h004, 9'h008, 1, 0, 0, 9'h00C);
      cyc(0, 0, 0, 0, 9'h000, w(2),  9'h008, 9'h00C, 1, 0, 0, 9'h010);
      cyc(0, 0, 0, 0, 9'h000, w(3),  9'h00C, 9'h010, 1, 0, 0, 9'h014);
      // joint stall at PCF=0x010
      cyc(0, 1, 1, 0, 9'h000, w(3),  9'h00C, 9'h010, 1, 0, 0, 9'h010);
      cyc(0, 1, 1, 0, 9'h000, w(3),  9'h00C, 9'h010, 1, 0, 0, 9'h010);
      cyc(0, 1, 1, 0, 9'h000, w(3),  9'h00C, 9'h010, 1, 0, 0, 9'h010);
      cyc(0, 0, 0, 0, 9'h000, w(4),  9'h010, 9'h014, 1, 0, 0, 9'h018);
      cyc(0, 0, 0, 0, 9'h000, w(5),  9'h014, 9'h018, 1, 0, 0, 9'h01C);
      // aligned redirect
      cyc(0, 0, 0, 1, 9'h040, 34'h0, 9'h000, 9'h000, 0, 0, 1, 9'h040);
      cyc(0, 0, 0, 0, 9'h000, w(16), 9'h040, 9'h044, 1, 0, 1, 9'h048);
      // misaligned redirect
      cyc(0, 0, 0, 1, 9'h043, 34'h0, 9'h000, 9'h000, 0, 1, 2, 9'h040);
      cyc(0, 0, 0, 0, 9'h000, w(16), 9'h040, 9'h044, 1, 0, 2, 9'h048);
      // back-to-back redirects, last wins
      cyc(0, 0, 0, 1, 9'h080, 34'h0, 9'h000, 9'h000, 0, 0, 3, 9'h080);
      cyc(0, 0, 0, 1, 9'h100, 34'h0, 9'h000, 9'h000, 0, 0, 4, 9'h100);
      cyc(0, 0, 0, 0, 9'h000, w(64), 9'h100, 9'h104, 1, 0, 4, 9'h108);
      // PC wrap from 0x1F8
      cyc(0, 0, 0, 1, 9'h1F8, 34'h0, 9'h000, 9'h000, 0, 0, 5, 9'h1F8);
      cyc(0, 0, 0, 0, 9'h000, w(126),9'h1F8, 9'h1FC, 1, 0, 5, 9'h000);
      cyc(0, 0, 0, 0, 9'h000, w(127),9'h1FC, 9'h000, 1, 0, 5, 9'h004);
      cyc(0, 0, 0, 0, 9'h000, w(0),  9'h000, 9'h004, 1, 0, 5, 9'h008);
      // StallF alone duplicates the held fetch
      cyc(0, 1, 0, 0, 9'h000, w(1),  9'h004, 9'h008, 1, 0, 5, 9'h004);
      cyc(0, 1, 0, 0, 9'h000, w(1),  9'h004, 9'h008, 1, 0, 5, 9'h004);
      cyc(0, 0, 0, 0, 9'h000, w(1),  9'h004, 9'h008, 1, 0, 5, 9'h00C);
      // redirect overrides both stalls
      cyc(0, 1, 1, 1, 9'h020, 34'h0, 9'h000, 9'h000, 0, 0, 6, 9'h020);
      cyc(0, 0, 0, 0, 9'h000, w(8),  9'h020, 9'h024, 1, 0, 6, 9'h028);
      // reset during a misaligned redirect and stall
      cyc(1, 1, 1, 1, 9'h081, 34'h0, 9'h000, 9'h000, 0, 0, 0, 9'h000);
      cyc(0, 0, 0, 0, 9'h000, w(0),  9'h000, 9'h004, 1, 0, 0, 9'h008);
      cyc(0, 0, 0, 0, 9'h000, w(1),  9'h004, 9'h008, 1, 0, 0, 9'h00C);
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
